// File: rtl/multi_lane_stall_pipeline_pkg.sv
// Shared types and helpers for the multi-lane stall pipeline.
//   DATA_W_DEF  : default lane data width
//   CNT_W_DEF   : default stall counter width
//   MAX_DATA_W  : widest lane the increment helper supports
//   stage_inc() : data + inc, computed at MAX_DATA_W; callers truncate
//   lane_stage_t: one stage slot (valid + data) at the default width
package multi_lane_stall_pipeline_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 32;
   localparam int MAX_DATA_W = 64;

   typedef struct packed {
      logic                  valid;
      logic [DATA_W_DEF-1:0] data;
   } lane_stage_t;

   // Wraps modulo 2^MAX_DATA_W; truncating to the lane width keeps the
   // result modulo 2^DATA_W as well.
   function automatic logic [MAX_DATA_W-1:0] stage_inc(input logic [MAX_DATA_W-1:0] data,
                                                       input logic [MAX_DATA_W-1:0] inc);
      return data + inc;
   endfunction

endpackage

// File: rtl/multi_lane_stall_pipeline_stage.sv
// One valid+data register of a pipeline lane.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : clears valid, data untouched
//   advance      : load from the previous stage (low = hold)
//   in_valid/in_data   : previous stage (or lane input)
//   out_valid/out_data : this stage's registered contents
module pipe_lane_stage
   import multi_lane_stall_pipeline_pkg::*;
#(
   parameter int                DATA_W    = DATA_W_DEF,
   parameter logic [DATA_W-1:0] STAGE_INC = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              advance,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (advance) begin
         valid_d = in_valid;
         // Bubbles leave the data register alone; its content is don't-care.
         if (in_valid) begin
            data_d = DATA_W'(stage_inc(MAX_DATA_W'(in_data), MAX_DATA_W'(STAGE_INC)));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/multi_lane_stall_pipeline.sv
// LANES x DEPTH datapath pipeline with one global stall shared by all lanes.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : drop every in-flight item
//   in_valid     : per-lane input valid       in_data  : lane i at [i*DATA_W +: DATA_W]
//   in_ready     : global, = ~stall
//   out_valid    : per-lane final-stage valid out_data : same packing as in_data
//   out_ready    : per-lane downstream ready
//   stall_count  : saturating count of stalled cycles since reset
module multi_lane_stall_pipeline
   import multi_lane_stall_pipeline_pkg::*;
#(
   parameter int                DATA_W    = DATA_W_DEF,
   parameter int                DEPTH     = 4,
   parameter int                LANES     = 2,
   parameter logic [DATA_W-1:0] STAGE_INC = 1,
   parameter int                CNT_W     = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [LANES-1:0]        in_valid,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    in_ready,
   output logic [LANES-1:0]        out_valid,
   output logic [LANES*DATA_W-1:0] out_data,
   input  logic [LANES-1:0]        out_ready,
   output logic [CNT_W-1:0]        stall_count
);

   logic [DEPTH-1:0]  stg_valid [LANES];
   logic [DATA_W-1:0] stg_data  [LANES][DEPTH];
   logic              stall;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Stall looks only at registered out_valid, so in_ready never depends on in_valid.
   assign stall    = |(out_valid & ~out_ready);
   assign in_ready = ~stall;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         logic              src_valid;
         logic [DATA_W-1:0] src_data;
         if (k == 0) begin : g_head
            assign src_valid = in_valid[l];
            assign src_data  = in_data[l*DATA_W +: DATA_W];
         end else begin : g_body
            assign src_valid = stg_valid[l][k-1];
            assign src_data  = stg_data[l][k-1];
         end
         pipe_lane_stage #(
            .DATA_W    (DATA_W),
            .STAGE_INC (STAGE_INC)
         ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .advance   (~stall),
            .in_valid  (src_valid),
            .in_data   (src_data),
            .out_valid (stg_valid[l][k]),
            .out_data  (stg_data[l][k])
         );
      end
      assign out_valid[l]                    = stg_valid[l][DEPTH-1];
      assign out_data[l*DATA_W +: DATA_W]    = stg_data[l][DEPTH-1];
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_count = cnt_q;

endmodule

// File: tb/tb_multi_lane_stall_pipeline.sv
module tb_multi_lane_stall_pipeline;

   localparam int DEPTH = 4;
   localparam int INC   = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic [1:0]  in_valid = '0;
   logic [63:0] in_data = '0;
   logic        in_ready, in_ready_s;
   logic [1:0]  out_valid, out_valid_s;
   logic [63:0] out_data, out_data_s;
   logic [1:0]  out_ready = 2'b11;
   logic [31:0] stall_count;
   logic [2:0]  stall_count_s;

   always #5 clk = ~clk;

   multi_lane_stall_pipeline #(.DATA_W(32), .DEPTH(DEPTH), .LANES(2), .STAGE_INC(32'(INC)), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .stall_count(stall_count));

   multi_lane_stall_pipeline #(.DATA_W(32), .DEPTH(DEPTH), .LANES(2), .STAGE_INC(32'(INC)), .CNT_W(3)) dut_s (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_s), .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
      .stall_count(stall_count_s));

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Model: each accepted item remembers how many advancing edges had occurred
   // when it entered; it is at the output once DEPTH more advances have passed.
   typedef struct {
      longint      a;
      logic [31:0] v;
   } item_t;

   item_t  lq [2][$];
   longint adv = 0;
   longint m_cnt = 0;
   int     m_cnt_s = 0;

   always @(negedge clk) begin
      logic [1:0] ev;
      logic       es;
      item_t      it;
      for (int l = 0; l < 2; l++)
         ev[l] = (lq[l].size() > 0) && ((adv - lq[l][0].a) == DEPTH);
      es = |(ev & ~out_ready);
      if (chk_en) begin
         chk("in_ready", 64'(in_ready), 64'(!es));
         chk("out_valid", 64'(out_valid), 64'(ev));
         for (int l = 0; l < 2; l++)
            if (ev[l]) chk($sformatf("out_data[%0d]", l), 64'(out_data[l*32 +: 32]),
                           64'(32'(lq[l][0].v + 32'(DEPTH*INC))));
         chk("stall_count", 64'(stall_count), 64'(m_cnt));
         chk("stall_count_sat", 64'(stall_count_s), 64'(m_cnt_s));
      end
      if (reset) begin
         lq[0].delete(); lq[1].delete();
         m_cnt = 0; m_cnt_s = 0;
      end else begin
         if (es) begin
            m_cnt++;
            if (m_cnt_s < 7) m_cnt_s++;
         end
         if (flush) begin
            lq[0].delete(); lq[1].delete();
         end else if (!es) begin
            for (int l = 0; l < 2; l++)
               if (ev[l]) void'(lq[l].pop_front());
            adv++;
            for (int l = 0; l < 2; l++)
               if (in_valid[l]) begin
                  it.a = adv - 1;
                  it.v = in_data[l*32 +: 32];
                  lq[l].push_back(it);
               end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int sv;
      ticks(2);
      reset = 1'b0;
      chk_en = 1'b1;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset out_data", out_data, 64'd0);

      // Basic latency
      in_valid = 2'b11; in_data = {32'd100, 32'd10}; out_ready = 2'b11;
      tick();
      in_valid = 2'b00;
      ticks(2);
      chk("lat early out_valid", 64'(out_valid), 64'd0);
      tick();
      chk("lat out_valid", 64'(out_valid), 64'd3);
      chk("lat lane0", 64'(out_data[31:0]), 64'd14);
      chk("lat lane1", 64'(out_data[63:32]), 64'd104);
      chk("lat stall_count", 64'(stall_count), 64'd0);
      tick();

      // Wrap
      in_valid = 2'b01; in_data = {32'd0, 32'hFFFF_FFFE};
      tick();
      in_valid = 2'b00;
      ticks(3);
      chk("wrap lane0", 64'(out_data[31:0]), 64'd2);
      tick();

      // Global stall
      sv = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 2'b11; in_data = {32'(sv + 1000), 32'(sv)};
         tick();
         sv++;
      end
      in_data = {32'(sv + 1000), 32'(sv)};
      out_ready = 2'b01;
      #1;
      chk("stall in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall hold lane0", 64'(out_data[31:0]), 64'd6);
         chk("stall hold lane1", 64'(out_data[63:32]), 64'd1006);
      end
      out_ready = 2'b11;
      #1;
      chk("stall count 3", 64'(stall_count), 64'd3);
      tick();
      sv++;
      chk("resume lane0", 64'(out_data[31:0]), 64'd7);
      chk("resume lane1", 64'(out_data[63:32]), 64'd1007);
      for (int i = 0; i < 2; i++) begin
         in_data = {32'(sv + 1000), 32'(sv)};
         tick();
         sv++;
      end
      in_valid = 2'b00;
      ticks(5);

      // Bubble: lane1 not ready but empty, so no stall
      in_valid = 2'b01; in_data = {32'd77, 32'd50}; out_ready = 2'b01;
      tick();
      in_valid = 2'b00;
      ticks(3);
      chk("bubble out_valid", 64'(out_valid), 64'd1);
      chk("bubble lane0", 64'(out_data[31:0]), 64'd54);
      chk("bubble in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("bubble stall_count", 64'(stall_count), 64'd3);
      out_ready = 2'b11;

      // Flush (coinciding with a stall, which is still counted)
      for (int i = 0; i < 4; i++) begin
         in_valid = 2'b11; in_data = {32'(i + 300), 32'(i + 200)};
         tick();
      end
      flush = 1'b1; in_data = {32'd999, 32'd999}; out_ready = 2'b00;
      tick();
      flush = 1'b0; in_valid = 2'b00; out_ready = 2'b11;
      chk("flush stall_count", 64'(stall_count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("flush out_valid", 64'(out_valid), 64'd0);
         if (i < 3) tick();
      end
      in_valid = 2'b01; in_data = {32'd0, 32'd500};
      tick();
      in_valid = 2'b00;
      ticks(3);
      chk("post-flush out_valid", 64'(out_valid), 64'd1);
      chk("post-flush lane0", 64'(out_data[31:0]), 64'd504);
      tick();

      // Reset mid-stream
      for (int i = 0; i < 3; i++) begin
         in_valid = 2'b11; in_data = {32'(i + 40), 32'(i + 20)};
         tick();
      end
      reset = 1'b1; in_valid = 2'b00;
      tick();
      reset = 1'b0;
      chk("midreset out_valid", 64'(out_valid), 64'd0);
      chk("midreset out_data", out_data, 64'd0);
      chk("midreset in_ready", 64'(in_ready), 64'd1);
      chk("midreset stall_count", 64'(stall_count), 64'd0);

      // Saturation
      in_valid = 2'b11; in_data = {32'd1, 32'd2};
      tick();
      in_valid = 2'b00;
      ticks(3);
      out_ready = 2'b00;
      ticks(10);
      chk("sat count 3-bit", 64'(stall_count_s), 64'd7);
      chk("sat count 32-bit", 64'(stall_count), 64'd10);
      out_ready = 2'b11;
      ticks(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_lane_stall_pipeline.md
Name: multi_lane_stall_pipeline

Overview:
Parametrised N-lane, D-stage datapath pipeline with a single global stall shared by all lanes.
- Each stage adds a fixed increment to valid data.
- A back-pressured output on any lane freezes every lane, so lanes stay cycle-aligned.
- Adds an input/output valid-ready handshake, synchronous flush and a saturating stall counter for performance monitoring.
- Replaces the fixed two-pipeline top as the datapath core under the global-stall top level.

Parameters:
- DATA_W, 32, data width per lane.
- DEPTH, 4, number of register stages per lane (≥1).
- LANES, 2, number of parallel lanes (≥1).
- STAGE_INC, 1, constant added to valid data at every stage, width DATA_W.
- CNT_W, 32, stall counter width.

Ports:
- clk  input  1  clock; all logic posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all in-flight valid bits.
- in_valid  input  LANES  per-lane input valid.
- in_data  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- in_ready  output  1  global; high when the pipeline accepts input this cycle.
- out_valid  output  LANES  per-lane valid at the final stage.
- out_data  output  LANES*DATA_W  final-stage data, same packing as in_data.
- out_ready  input  LANES  per-lane downstream ready.
- stall_count  output  CNT_W  cycles with stall asserted since reset.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all stage valid = 0, all stage data = 0, stall_count = 0. Therefore out_valid = 0 and out_data = 0 in the cycle after reset is sampled high.
- Stall: stall = OR over i of (out_valid[i] & ~out_ready[i]). Combinational from registered out_valid and the out_ready input.
  - in_valid does not affect stall.
  - A lane with out_valid = 0 never causes a stall.
- in_ready = ~stall. No combinational path from in_valid to in_ready.
- Advance when stall = 0, every lane:
  - stage0.valid <= in_valid[i].
  - stage0.data <= in_data[i] + STAGE_INC if in_valid[i], else hold the old data (don't-care).
  - stage k.valid <= stage k-1.valid.
  - stage k.data <= stage k-1.data + STAGE_INC if stage k-1.valid, else hold.
- Hold when stall = 1: all stage registers in all lanes hold. Inputs are ignored (not captured).
- Arithmetic: all additions are modulo 2^DATA_W and wrap silently.
  - Output = input + DEPTH*STAGE_INC mod 2^DATA_W.
- Latency: exactly DEPTH cycles from acceptance (in_valid & in_ready at edge) to out_valid, with no stalls in between.
  - Each stall cycle adds one cycle.
- Throughput: 1 item per lane per cycle when unstalled.
  - Bubbles propagate; there is no bubble collapse, so lanes stay aligned.
- Output transfer: occurs on out_valid[i] & out_ready[i] at a non-stalled edge.
  - If another lane stalls, a lane whose ready is high keeps its item.
  - That item is presented again with the same data; no duplication or loss.
- Flush: on an edge with flush = 1, all stage valid bits clear.
  - Data registers are unchanged. stall_count is unchanged.
  - Inputs are not captured that cycle.
  - Priority: reset > flush > stall/advance.
- stall_count: increments by 1 on each edge where stall = 1 and reset = 0. This includes flush cycles.
  - Saturates at 2^CNT_W − 1; no wrap.
- Reset mid-stream: discards all items. in_ready depends only on state, so it is 1 the cycle after reset.
- Simultaneous stall and in_valid: the input is not accepted. The source must hold it (valid-ready rule).
- DEPTH = 1: stage0 is the output stage. The stall feedback remains registered-output based.

Decomposition:
- Package multi_lane_stall_pipeline_pkg: DATA_W/CNT_W defaults, a stage-increment function (data + STAGE_INC, width-truncated), and a lane_stage_t struct {valid, data}.
- Sub-module pipe_lane_stage: one valid+data register with advance, flush and reset inputs and the increment.
- Top generates the LANES × DEPTH array, the stall reduction and the counter.

Test Plan:
- Basic latency (LANES=2, DEPTH=4, INC=1; out_ready=11): lane0 in 10, lane1 in 100 at cycle 0 → out_valid=11 at cycle 4 with out_data 14/104; stall_count=0.
- Wrap: in_data lane0 = 0xFFFFFFFE → output 0x00000002 after 4 cycles.
- Global stall: stream 0,1,2,… on both lanes. Drop out_ready[1]=0 for 3 cycles while out_valid[1]=1 →
  - in_ready=0 for those 3 cycles;
  - lane0 out_data holds and is not consumed despite out_ready[0]=1;
  - after release, lanes resume in lockstep with no missing/duplicated values;
  - stall_count=3.
- Bubble, no stall: in_valid=01 → out_valid=01; out_ready[1]=0 produces no stall, since lane1 out_valid=0.
- Flush: 4 items in flight, flush pulse for 1 cycle → out_valid=00 for the next 4 cycles; a new input accepted after flush appears at latency 4.
- Reset mid-stream and saturation:
  - reset with items in flight → all outputs 0 the next cycle, in_ready=1.
  - With CNT_W=3, hold stall for 10 cycles → stall_count=7.
